// File: rtl/hazard_scoreboard_if.sv
// Decode/Execute issue channel for the hazard scoreboard: issue request in,
// stall / forwarding / busy status out.
interface hazard_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int MAX_LAT  = 4
);
   localparam int AW = $clog2(NUM_REGS);
   localparam int CW = $clog2(MAX_LAT + 2);

   logic                   issue_valid;
   logic                   flush;
   logic                   issue_we;
   logic [AW-1:0]          issue_rd;
   logic [CW-1:0]          issue_lat;
   logic [NUM_SRC*AW-1:0]  issue_rs;
   logic [NUM_SRC-1:0]     issue_rs_used;
   logic                   issue_stall;
   logic [NUM_SRC-1:0]     fwd_hit;
   logic                   busy;

   modport master (
      output issue_valid, flush, issue_we, issue_rd, issue_lat, issue_rs, issue_rs_used,
      input  issue_stall, fwd_hit, busy
   );

   modport slave (
      input  issue_valid, flush, issue_we, issue_rd, issue_lat, issue_rs, issue_rs_used,
      output issue_stall, fwd_hit, busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register writeback countdown for variable-latency Execute paths; yields the
// issue stall (RAW, WAW, writeback-port collision) and per-source bypass hits.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int MAX_LAT  = 4,
   parameter int NUM_WB   = 1
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave bus
);
   localparam int AW   = $clog2(NUM_REGS);
   localparam int CW   = $clog2(MAX_LAT + 2);
   localparam int NW   = $clog2(NUM_REGS + 1);

   logic [CW-1:0]      cnt_r [1:NUM_REGS-1];
   logic [CW-1:0]      cnt_s [NUM_REGS];
   logic [CW-1:0]      lat_s;
   logic [CW-1:0]      lat_next_s;
   logic [NW-1:0]      wb_cnt_s;
   logic               busy_s;
   logic               raw_s;
   logic [NUM_SRC-1:0] fwd_s;
   logic               rd_live_s;
   logic               waw_s;
   logic               wbc_s;
   logic               req_s;
   logic               stall_s;
   logic               wr_s;

   // Flat view of the counters with register 0 pinned to zero.
   always_comb begin
      cnt_s[0] = {CW{1'b0}};
      for (int r = 1; r < NUM_REGS; r++) begin
         cnt_s[r] = cnt_r[r];
      end
   end

   // Clamp requested latency into 1..MAX_LAT.
   always_comb begin
      if (bus.issue_lat == {CW{1'b0}}) begin
         lat_s = CW'(1);
      end else if (bus.issue_lat > CW'(MAX_LAT)) begin
         lat_s = CW'(MAX_LAT);
      end else begin
         lat_s = bus.issue_lat;
      end
      lat_next_s = lat_s + CW'(1);
   end

   // Counters equal to L+1 land on the same writeback cycle as the new instruction.
   always_comb begin
      wb_cnt_s = {NW{1'b0}};
      busy_s   = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (cnt_r[r] == lat_next_s) begin
            wb_cnt_s = wb_cnt_s + NW'(1);
         end else begin
            wb_cnt_s = wb_cnt_s;
         end
         if (cnt_r[r] != {CW{1'b0}}) begin
            busy_s = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
   end

   // Source operand hazards: still in flight stalls, due this cycle forwards.
   always_comb begin
      raw_s = 1'b0;
      fwd_s = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.issue_rs_used[i] && (bus.issue_rs[i*AW +: AW] != {AW{1'b0}})) begin
            if (cnt_s[bus.issue_rs[i*AW +: AW]] > CW'(1)) begin
               raw_s = 1'b1;
            end else if (cnt_s[bus.issue_rs[i*AW +: AW]] == CW'(1)) begin
               fwd_s[i] = 1'b1;
            end else begin
               fwd_s[i] = 1'b0;
            end
         end else begin
            fwd_s[i] = 1'b0;
         end
      end
   end

   // Destination hazards and the final issue decision.
   always_comb begin
      rd_live_s = bus.issue_we && (bus.issue_rd != {AW{1'b0}});
      waw_s     = rd_live_s && (cnt_s[bus.issue_rd] > CW'(1));
      wbc_s     = rd_live_s && (wb_cnt_s >= NW'(NUM_WB));
      req_s     = bus.issue_valid && !bus.flush;
      stall_s   = req_s && (raw_s || waw_s || wbc_s);
      wr_s      = req_s && !stall_s && rd_live_s;
   end

   assign bus.issue_stall = stall_s;
   assign bus.fwd_hit     = fwd_s;
   assign bus.busy        = busy_s;

   // Countdown per register; an accepted write reloads its destination instead.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            cnt_r[r] <= {CW{1'b0}};
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (wr_s && (bus.issue_rd == AW'(r))) begin
               cnt_r[r] <= lat_s;
            end else if (cnt_r[r] != {CW{1'b0}}) begin
               cnt_r[r] <= cnt_r[r] - CW'(1);
            end else begin
               cnt_r[r] <= cnt_r[r];
            end
         end
      end
   end
endmodule
